// File: rtl/seg7_pkg.sv
// Shared constants and types for the multiplexed seven-segment display driver.
// All segment patterns are active low and ordered {g,f,e,d,c,b,a}.
package seg7_pkg;

  // Pattern with every segment dark.
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  // Only the middle bar (g) lit, shown instead of hex when the stack is empty.
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  // All anodes released (common-anode, active-low drive).
  localparam logic [3:0] AN_OFF    = 4'b1111;

  // Hex font 0..F; lower-case b and d keep them distinct from 8 and 0.
  localparam logic [6:0] HEX_SEG_TABLE [16] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000,  // 9
    7'b0001000,  // A
    7'b0000011,  // b
    7'b1000110,  // C
    7'b0100001,  // d
    7'b0000110,  // E
    7'b0001110   // F
  };

  // Each digit slot starts dark (dead time against ghosting), then lights.
  typedef enum logic {
    PH_BLANK = 1'b0,
    PH_ON    = 1'b1
  } phase_e;

  // Active-low anode pattern selecting exactly one digit.
  function automatic logic [3:0] an_for_idx(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/seg7_display_mux_if.sv
// Display-side bundle: the calculator's display registers going in and the
// multiplexed anode/segment drive coming out.
interface seg7_display_mux_if;

  logic [7:0] value;  // data value, shown on digits 1..0
  logic [6:0] addr;   // display address, shown on digits 3..2
  logic       empty;  // stack-empty flag, dashes out the value digits
  logic [3:0] an;     // digit anodes, active low, an[0] rightmost
  logic [6:0] seg;    // segments {g,f,e,d,c,b,a}, active low
  logic       dp;     // decimal point, active low

  // Producer of the display data (calculator side, or a bench).
  modport master (
    output value, addr, empty,
    input  an, seg, dp
  );

  // The display driver itself.
  modport slave (
    input  value, addr, empty,
    output an, seg, dp
  );

endinterface

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment pattern.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg_n
);

  // Straight table lookup; the font lives in the package so it is shared.
  assign seg_n = HEX_SEG_TABLE[hex];

endmodule

// File: rtl/seg7_display_mux.sv
// Four-digit multiplexed seven-segment driver for the stack calculator's
// display registers. Each digit owns a slot of REFRESH_DIV cycles whose first
// DEAD_CYCLES cycles are dark. Inputs are captured once per frame (at the
// start of digit 0's slot) so all four digits show one coherent sample.
// Requires REFRESH_DIV > DEAD_CYCLES >= 1.
module seg7_display_mux
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int DEAD_CYCLES = 1000
) (
  input  logic               clk,
  input  logic               rst,
  seg7_display_mux_if.slave  bus
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] DEAD_START = CNT_W'(DEAD_CYCLES);

  // Slot counter and digit index.
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;

  // Per-frame snapshot of the inputs.
  logic [7:0] value_q, value_d;
  logic [6:0] addr_q,  addr_d;
  logic       empty_q, empty_d;

  // Registered display drive.
  logic [3:0] an_q,  an_d;
  logic [6:0] seg_q, seg_d;
  logic       dp_q,  dp_d;

  logic       snap;
  phase_e     phase_d;
  logic [15:0] disp_word_d;
  logic [3:0]  digit_d [4];
  logic [3:0]  nib_d;
  logic [6:0]  hex_seg_d;

  // Advance the slot counter; wrap is explicit so no overflow can occur.
  always_comb begin
    cnt_d = cnt_q;
    idx_d = idx_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Capture inputs at the first cycle of each frame; hold them otherwise.
  always_comb begin
    snap    = (cnt_q == '0) && (idx_q == 2'd0);
    value_d = value_q;
    addr_d  = addr_q;
    empty_d = empty_q;
    if (snap) begin
      value_d = bus.value;
      addr_d  = bus.addr;
      empty_d = bus.empty;
    end
  end

  // The four displayed nibbles, lowest digit in the lowest bits.
  assign disp_word_d = {1'b0, addr_d, value_d};

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_digit
      assign digit_d[gi] = disp_word_d[4*gi +: 4];
    end
  endgenerate

  assign nib_d = digit_d[idx_d];

  hex_to_seg7 u_hex_to_seg7 (
    .hex   (nib_d),
    .seg_n (hex_seg_d)
  );

  // Output pattern for the cycle being entered, so the output flops never
  // lag the counter state they belong to.
  always_comb begin
    phase_d = (cnt_d < DEAD_START) ? PH_BLANK : PH_ON;
    an_d    = AN_OFF;
    seg_d   = SEG_BLANK;
    dp_d    = 1'b1;
    if (phase_d == PH_ON) begin
      an_d = an_for_idx(idx_d);
      if (empty_d && (idx_d < 2'd2)) begin
        seg_d = SEG_DASH;
      end else begin
        seg_d = hex_seg_d;
      end
      // Point on digit 2 separates the address from the value.
      dp_d = (idx_d != 2'd2);
    end
  end

  // State and output registers; reset aborts any scan in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      idx_q   <= 2'd0;
      value_q <= 8'd0;
      addr_q  <= 7'd0;
      empty_q <= 1'b0;
      an_q    <= AN_OFF;
      seg_q   <= SEG_BLANK;
      dp_q    <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      value_q <= value_d;
      addr_q  <= addr_d;
      empty_q <= empty_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end

  assign bus.an  = an_q;
  assign bus.seg = seg_q;
  assign bus.dp  = dp_q;

endmodule

// File: tb/tb_seg7_display_mux.sv
// Self-checking bench for seg7_display_mux with a short slot (8 cycles, 2 dark).
module tb_seg7_display_mux;

  localparam int R     = 8;
  localparam int D     = 2;
  localparam int FRAME = 4 * R;

  localparam logic [6:0] FONT [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } out_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seg7_display_mux_if bus_if ();

  seg7_display_mux #(
    .REFRESH_DIV (R),
    .DEAD_CYCLES (D)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  out_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic count_en = 1'b0;
  int   low_cnt [4];
  int   falls    = 0;
  int   last_fall = -1;
  int   cyc      = 0;

  // Expected display for time tt cycles into an uninterrupted scan.
  function automatic out_t model_out(input int tt, input logic [7:0] v,
                                     input logic [6:0] a, input logic e);
    out_t r;
    int c;
    int k;
    logic [15:0] word;
    logic [3:0] nib;
    c = tt % R;
    k = (tt / R) % 4;
    r.an  = 4'b1111;
    r.seg = 7'b1111111;
    r.dp  = 1'b1;
    if (c >= D) begin
      word  = {1'b0, a, v};
      nib   = 4'(word >> (4 * k));
      r.an[k] = 1'b0;
      r.seg = (e && k < 2) ? 7'b0111111 : FONT[nib];
      r.dp  = (k != 2);
    end
    return r;
  endfunction

  // Reference model: time since reset plus a frame-start snapshot.
  initial begin
    int t;
    logic [7:0] sv;
    logic [6:0] sa;
    logic se;
    out_t blank;
    blank = '{an: 4'b1111, seg: 7'b1111111, dp: 1'b1};
    t = 0; sv = '0; sa = '0; se = 1'b0;
    forever begin
      @(posedge clk);
      if (rst) begin
        t = 0;
        exp_q.push_back(blank);
      end else begin
        if (t % FRAME == 0) begin
          sv = bus_if.value;
          sa = bus_if.addr;
          se = bus_if.empty;
        end
        t++;
        exp_q.push_back(model_out(t, sv, sa, se));
      end
    end
  end

  // Monitor: compare every output cycle against the scoreboard.
  initial begin
    out_t e;
    out_t got;
    logic prev_an0;
    prev_an0 = 1'b1;
    for (int k = 0; k < 4; k++) low_cnt[k] = 0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      got = '{an: bus_if.an, seg: bus_if.seg, dp: bus_if.dp};
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_underflow cyc=%0d got an=%b seg=%b dp=%b required an expected entry",
                 cyc, got.an, got.seg, got.dp);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          n_fail++;
          $display("FAIL outputs cyc=%0d got an=%b seg=%b dp=%b required an=%b seg=%b dp=%b",
                   cyc, got.an, got.seg, got.dp, e.an, e.seg, e.dp);
        end
      end
      n_checks++;
      if ($countones(~bus_if.an) > 1) begin
        n_fail++;
        $display("FAIL one_anode cyc=%0d got an=%b required at most one low", cyc, bus_if.an);
      end
      if (count_en) begin
        for (int k = 0; k < 4; k++) if (bus_if.an[k] == 1'b0) low_cnt[k]++;
        if (prev_an0 && !bus_if.an[0]) begin
          if (last_fall >= 0) begin
            n_checks++;
            if (cyc - last_fall != FRAME) begin
              n_fail++;
              $display("FAIL frame_period cyc=%0d got %0d required %0d", cyc, cyc - last_fall, FRAME);
            end
          end
          last_fall = cyc;
          falls++;
        end
      end
      prev_an0 = bus_if.an[0];
    end
  end

  task automatic drive(input logic [7:0] v, input logic [6:0] a, input logic e, input string tag);
    bus_if.value = v;
    bus_if.addr  = a;
    bus_if.empty = e;
    $display("txn %s: value=%h addr=%h empty=%b", tag, v, a, e);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Stimulus: directed scenarios, then randomized traffic and resets.
  initial begin
    drive(8'h00, 7'h00, 1'b0, "init");
    rst = 1'b1;
    wait_cycles(5);

    drive(8'hA5, 7'h3C, 1'b0, "a5_3c");
    rst = 1'b0;
    wait_cycles(FRAME + R + 4);           // inside digit 1 ON of frame 1
    drive(8'hA5, 7'h11, 1'b0, "addr_midframe");
    wait_cycles(3 * FRAME - (FRAME + R + 4));

    drive(8'hFF, 7'h11, 1'b1, "empty");
    wait_cycles(2 * FRAME);
    wait_cycles(2 * R + 4);               // inside digit 2 ON
    rst = 1'b1;
    $display("txn reset during digit 2");
    wait_cycles(1);
    rst = 1'b0;

    wait_cycles(R);
    rst = 1'b1;
    wait_cycles(1);
    rst = 1'b0;
    count_en = 1'b1;
    for (int i = 0; i < 10 * FRAME; i++) begin
      if ($urandom_range(5) == 0)
        drive(8'($urandom), 7'($urandom), 1'($urandom_range(3) == 0), "rand");
      @(negedge clk);
    end
    count_en = 1'b0;
    wait_cycles(1);

    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (low_cnt[k] != 10 * (R - D)) begin
        n_fail++;
        $display("FAIL anode_low_time an[%0d] got %0d required %0d", k, low_cnt[k], 10 * (R - D));
      end
    end
    n_checks++;
    if (falls != 10) begin
      n_fail++;
      $display("FAIL frame_count got %0d required 10", falls);
    end

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(7) == 0)
        drive(8'($urandom), 7'($urandom), 1'($urandom_range(2) == 0), "rand2");
      rst = ($urandom_range(60) == 0);
      if (rst) $display("txn random reset");
      @(negedge clk);
    end
    rst = 1'b0;
    wait_cycles(3);

    n_checks++;
    if (exp_q.size() > 1) begin
      n_fail++;
      $display("FAIL scoreboard_drain got %0d pending required at most 1", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
